// File: rtl/skinny_inv_sbox8_dom1_seq.sv
// First-order DOM-masked inverse SKINNY 8-bit S-box, self-sequenced.
// Eight NOR/XOR gadgets run in four dependency stages. Each stage has six
// one-hot phases, and every phase evaluates one partial product.
// Every operand is gated by its phase bit before use, so a share pair that
// must stay apart is never live in the same cycle.
module skinny_inv_sbox8_dom1_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] si0,
  input  logic [7:0] si1,
  input  logic [7:0] r,
  output logic       busy,
  output logic       done,
  output logic [7:0] so0,
  output logic [7:0] so1
);

  // Gadget map, indexed by the recovered bit x[i].
  // Source code: bit 3 set = x bit (gadget result), clear = y bit (input share).
  //                                   x7     x6     x5     x4     x3     x2     x1     x0
  localparam logic [7:0][3:0] A_SRC = {4'h2,  4'hA,  4'h6,  4'hF,  4'h7,  4'h3,  4'h5,  4'hB};
  localparam logic [7:0][3:0] B_SRC = {4'h7,  4'h9,  4'h5,  4'hE,  4'h6,  4'h1,  4'hB,  4'hA};
  localparam logic [7:0][3:0] C_SRC = {4'h1,  4'h2,  4'h7,  4'h6,  4'h4,  4'h0,  4'h3,  4'h5};
  localparam logic [7:0][2:0] R_IDX = {3'd2,  3'd6,  3'd3,  3'd7,  3'd1,  3'd0,  3'd4,  3'd5};
  localparam logic [7:0][1:0] STAGE = {2'd0,  2'd2,  2'd0,  2'd3,  2'd0,  2'd0,  2'd1,  2'd1};

  logic [23:0] phase, phase_nxt;
  logic        capture;
  logic [7:0]  y_s0, y_s1, r_reg;
  logic [7:0]  g0, g1, t0, t1, f0, f1;

  // Phase-gated operands, one bit per gadget, grouped by the phase that owns them.
  logic [7:0] a1g0, b1g0, c1g0;
  logic [7:0] a0g1, b0g1, c0g1;
  logic [7:0] a1g2, b0g2, rg2;
  logic [7:0] a0g3, b1g3, rg3;
  logic [7:0] t0g4, g0g4;
  logic [7:0] t1g5, g1g5;

  // Per-gadget next values and phase enables.
  logic [7:0] g1_nx, g0_nx, t1_nx, t0_nx, f0_nx, f1_nx;
  logic [7:0] en0, en1, en2, en3, en4, en5;

  for (genvar i = 0; i < 8; i++) begin : g_gadget
    localparam int S = int'(STAGE[i]);
    localparam logic [3:0] AS = A_SRC[i];
    localparam logic [3:0] BS = B_SRC[i];
    localparam logic [3:0] CS = C_SRC[i];
    localparam logic [2:0] RI = R_IDX[i];

    logic [5:0] ph;
    logic a1, a0, b1, b0, c1, c0;

    assign ph = phase[6*S +: 6];
    assign a1 = AS[3] ? f1[AS[2:0]] : y_s1[AS[2:0]];
    assign a0 = AS[3] ? f0[AS[2:0]] : y_s0[AS[2:0]];
    assign b1 = BS[3] ? f1[BS[2:0]] : y_s1[BS[2:0]];
    assign b0 = BS[3] ? f0[BS[2:0]] : y_s0[BS[2:0]];
    assign c1 = CS[3] ? f1[CS[2:0]] : y_s1[CS[2:0]];
    assign c0 = CS[3] ? f0[CS[2:0]] : y_s0[CS[2:0]];

    assign a1g0[i] = a1 & ph[0];
    assign b1g0[i] = b1 & ph[0];
    assign c1g0[i] = c1 & ph[0];
    assign a0g1[i] = a0 & ph[1];
    assign b0g1[i] = b0 & ph[1];
    assign c0g1[i] = c0 & ph[1];
    assign a1g2[i] = a1 & ph[2];
    assign b0g2[i] = b0 & ph[2];
    assign rg2[i]  = r_reg[RI] & ph[2];
    assign a0g3[i] = a0 & ph[3];
    assign b1g3[i] = b1 & ph[3];
    assign rg3[i]  = r_reg[RI] & ph[3];
    assign t0g4[i] = t0[i] & ph[4];
    assign g0g4[i] = g0[i] & ph[4];
    assign t1g5[i] = t1[i] & ph[5];
    assign g1g5[i] = g1[i] & ph[5];

    // Complemented share 1 gives the NOR; the phase bit keeps it quiet outside.
    assign g1_nx[i] = (~a1g0[i] & ~b1g0[i] & ph[0]) ^ c1g0[i];
    assign g0_nx[i] = (a0g1[i] & b0g1[i]) ^ c0g1[i];
    assign t1_nx[i] = (~a1g2[i] & b0g2[i]) ^ rg2[i];
    assign t0_nx[i] = (a0g3[i] & ~b1g3[i]) ^ rg3[i];
    assign f0_nx[i] = t0g4[i] ^ g0g4[i];
    assign f1_nx[i] = t1g5[i] ^ g1g5[i];

    assign en0[i] = ph[0];
    assign en1[i] = ph[1];
    assign en2[i] = ph[2];
    assign en3[i] = ph[3];
    assign en4[i] = ph[4];
    assign en5[i] = ph[5];
  end

  // Sequencer outputs: busy while any phase bit is set, capture only when idle.
  always_comb begin
    busy    = |phase;
    capture = start & ~(|phase);
  end

  // Next phase: load bit 0 on capture, otherwise shift toward the end.
  always_comb begin
    phase_nxt = {phase[22:0], 1'b0};
    if (capture) phase_nxt = 24'd1;
  end

  // Phase register and the done pulse that follows the last phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      done  <= 1'b0;
    end else begin
      phase <= phase_nxt;
      done  <= phase[23];
    end
  end

  // Datapath: capture shares, update each gadget register only in its phase,
  // and publish all output shares once the last phase completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_s0  <= '0;
      y_s1  <= '0;
      r_reg <= '0;
      g0    <= '0;
      g1    <= '0;
      t0    <= '0;
      t1    <= '0;
      f0    <= '0;
      f1    <= '0;
      so0   <= '0;
      so1   <= '0;
    end else begin
      if (capture) begin
        y_s0  <= si0;
        y_s1  <= si1;
        r_reg <= r;
      end
      for (int i = 0; i < 8; i++) begin
        if (en0[i]) g1[i] <= g1_nx[i];
        if (en1[i]) g0[i] <= g0_nx[i];
        if (en2[i]) t1[i] <= t1_nx[i];
        if (en3[i]) t0[i] <= t0_nx[i];
        if (en4[i]) f0[i] <= f0_nx[i];
        if (en5[i]) f1[i] <= f1_nx[i];
      end
      if (phase[23]) begin
        so0 <= (f0 & ~en4) | (f0_nx & en4);
        so1 <= (f1 & ~en5) | (f1_nx & en5);
      end
    end
  end

endmodule

// File: tb/tb_skinny_inv_sbox8_dom1_seq.sv
// Bench for the masked inverse SKINNY S-box: vector table, exhaustive sweep,
// handshake, reset abort and phase-gating leak checks, with a scoreboard of
// expected results and done cycles.
module tb_skinny_inv_sbox8_dom1_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] si0, si1, r;
  logic       busy, done;
  logic [7:0] so0, so1;

  typedef struct {
    logic [7:0] si0;
    logic [7:0] si1;
    logic [7:0] r;
    logic [7:0] expx;
  } vec_t;

  typedef struct {
    logic [7:0] expx;
    int         due;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];
  exp_t ent;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   stage_of [8] = '{1, 1, 0, 0, 3, 0, 2, 0};
  logic [7:0] leak;
  logic [5:0] act, allow;

  skinny_inv_sbox8_dom1_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .si0   (si0),
    .si1   (si1),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .so0   (so0),
    .so1   (so1)
  );

  // Free-running clock and an edge counter used for latency checks.
  always #5 clk = ~clk;

  // Count rising edges so done timing can be compared to the capture edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Forward SKINNY 8-bit S-box: three round/permute steps and a final bit swap.
  function automatic logic [7:0] s8(input logic [7:0] xin);
    logic [7:0] x;
    x = xin;
    for (int k = 0; k < 4; k++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (k < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
      else       x = {x[7:3], x[1], x[2], x[0]};
    end
    return x;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Called at a negedge: drive one request, let the next rising edge sample it.
  task automatic applyStimulus(input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] rr, input logic [7:0] ex, input bit push);
    exp_t e;
    si0   = a0;
    si1   = a1;
    r     = rr;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.expx = ex;
      e.due  = cyc + 24;
      sb.push_back(e);
    end
    start = 1'b0;
    si0   = 8'($urandom);
    si1   = 8'($urandom);
    r     = 8'($urandom);
  endtask

  // Wait (bounded) until the block is idle again; returns at a negedge.
  task automatic waitIdle();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checkOutput("idle_timeout", 1, 0);
  endtask

  // Scoreboard: every done pulse must match the oldest pending request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        ent = sb.pop_front();
        checkOutput("result", int'(so0 ^ so1), int'(ent.expx));
        checkOutput("done_cycle", cyc, ent.due);
        checkOutput("busy_in_done", int'(busy), 0);
      end
    end
  end

  // Gated operands of each gadget must be zero outside that gadget's phases.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      leak = '0;
      for (int i = 0; i < 8; i++) begin
        act = {dut.t1g5[i] | dut.g1g5[i],
               dut.t0g4[i] | dut.g0g4[i],
               dut.a0g3[i] | dut.b1g3[i] | dut.rg3[i],
               dut.a1g2[i] | dut.b0g2[i] | dut.rg2[i],
               dut.a0g1[i] | dut.b0g1[i] | dut.c0g1[i],
               dut.a1g0[i] | dut.b1g0[i] | dut.c1g0[i]};
        allow = dut.phase[stage_of[i]*6 +: 6];
        if ((act & ~allow) != 6'd0) leak[i] = 1'b1;
      end
      checkOutput("phase_gating", int'(leak), 0);
    end
  end

  initial begin
    logic [7:0] m;
    rst_n = 1'b0;
    start = 1'b0;
    si0   = '0;
    si1   = '0;
    r     = '0;

    vecs[0] = '{8'h65, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{8'hE9, 8'hA5, 8'h3C, 8'h01};
    vecs[2] = '{8'hCF, 8'hA5, 8'h3C, 8'h02};
    vecs[3] = '{8'h3F, 8'h5A, 8'hFF, 8'h00};
    vecs[4] = '{8'hA6, 8'hC3, 8'h5A, 8'h00};
    vecs[5] = '{8'h4C, 8'h00, 8'hFF, 8'h01};

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_so0", int'(so0), 0);
    checkOutput("reset_so1", int'(so1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] vector table");
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].si0, vecs[v].si1, vecs[v].r, vecs[v].expx, 1'b1);
      waitIdle();
    end

    $display("[TB] exhaustive sweep");
    for (int x = 0; x < 256; x++) begin
      m = 8'($urandom);
      applyStimulus(s8(8'(x)) ^ m, m, 8'($urandom), 8'(x), 1'b1);
      waitIdle();
    end

    $display("[TB] handshake");
    applyStimulus(8'hE9, 8'hA5, 8'h3C, 8'h01, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h00, 1'b0);
    checkOutput("busy_after_ignored", int'(busy), 1);
    checkOutput("hold_mid_run", int'(so0 ^ so1), 8'hFF);
    repeat (6) @(negedge clk);
    applyStimulus(8'h9A, 8'hBC, 8'hDE, 8'h00, 1'b0);
    waitIdle();
    checkOutput("done_seen", int'(done), 1);
    applyStimulus(8'hCF, 8'hA5, 8'h3C, 8'h02, 1'b1);
    waitIdle();

    $display("[TB] reset abort");
    applyStimulus(8'h4C, 8'h00, 8'h00, 8'h01, 1'b1);
    repeat (14) @(negedge clk);
    checkOutput("phase13_busy", int'(dut.phase[13]), 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_so0", int'(so0), 0);
    checkOutput("abort_so1", int'(so1), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("idle_after_abort", int'(busy), 0);
    applyStimulus(8'hE9, 8'hA5, 8'h3C, 8'h01, 1'b1);
    waitIdle();
    repeat (2) @(negedge clk);

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
